// File: rtl/fmdll_lock_ctrl.sv
// fmdll_lock_ctrl
//   Closed-loop lock controller for the FMDLL. It compares the CLK_out edge count
//   measured over a CLK_exit window against the target (M+1)*win_len. It first
//   acquires the 10-bit DCDL code by binary search, then tracks in +/-1 steps and
//   raises lock after LOCK_HITS consecutive in-tolerance windows.
//   Single clock domain (CLK_exit), synchronous active-high reset.
module fmdll_lock_ctrl #(
  parameter int CODE_W    = 10,
  parameter int CNT_W     = 9,
  parameter int TOL       = 1,
  parameter int LOCK_HITS = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              CLK_exit,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        M,
  input  logic [2:0]        N,
  output logic              win_start,
  input  logic              meas_valid,
  input  logic [CNT_W-1:0]  meas_cnt,
  output logic [CODE_W-1:0] dcdl_code,
  output logic              code_upd,
  output logic              lock,
  output logic              busy
);

  localparam int BIT_W = $clog2(CODE_W);
  localparam int HIT_W = $clog2(LOCK_HITS + 1);
  localparam int WIN_W = 7;  // win_len tops out at 8*8 = 64
  localparam int TMR_W = ($clog2(TIMEOUT + 1) > WIN_W) ? $clog2(TIMEOUT + 1) : WIN_W;
  localparam logic signed [CNT_W:0] TOL_S = (CNT_W + 1)'(TOL);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAR_MEAS,
    ST_SAR_EVAL,
    ST_TRK_MEAS,
    ST_TRK_EVAL
  } state_t;

  // Sub-phases of a measurement: window start pulse, window run, wait for result.
  typedef enum logic [1:0] {
    PH_START,
    PH_WIN,
    PH_WAIT
  } phase_t;

  // State registers
  state_t             r_state;
  phase_t             r_phase;
  logic [TMR_W-1:0]   r_timer;
  logic               r_en_d;
  logic [WIN_W-1:0]   r_win_len;
  logic [CNT_W-1:0]   r_target;
  logic [CNT_W-1:0]   r_meas;
  logic [CODE_W-1:0]  r_code;
  logic [BIT_W-1:0]   r_bit;
  logic [HIT_W-1:0]   r_hits;
  logic               r_lock;
  logic               r_code_upd;

  // Next-state values
  state_t             w_state_nxt;
  phase_t             w_phase_nxt;
  logic [TMR_W-1:0]   w_timer_nxt;
  logic [WIN_W-1:0]   w_win_len_nxt;
  logic [CNT_W-1:0]   w_target_nxt;
  logic [CNT_W-1:0]   w_meas_nxt;
  logic [CODE_W-1:0]  w_code_nxt;
  logic [BIT_W-1:0]   w_bit_nxt;
  logic [HIT_W-1:0]   w_hits_nxt;
  logic               w_lock_nxt;
  logic               w_force_upd;
  logic               w_code_upd_nxt;

  // Combinational helpers
  logic               w_en_rise;
  logic [3:0]         w_n_p1;
  logic [2:0]         w_m_p1;
  logic [WIN_W-1:0]   w_win_len_calc;
  logic [CNT_W-1:0]   w_target_calc;
  logic signed [CNT_W:0] w_err;

  assign w_en_rise      = en & ~r_en_d;
  assign w_n_p1         = {1'b0, N} + 4'd1;
  assign w_m_p1         = {1'b0, M} + 3'd1;
  assign w_win_len_calc = {w_n_p1, 3'b000};
  assign w_target_calc  = CNT_W'(w_win_len_calc) * CNT_W'(w_m_p1);
  assign w_err          = $signed({1'b0, r_meas}) - $signed({1'b0, r_target});

  assign dcdl_code = r_code;
  assign code_upd  = r_code_upd;
  assign lock      = r_lock;

  // Next-state, datapath and Moore outputs of the lock FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_timer_nxt   = r_timer;
    w_win_len_nxt = r_win_len;
    w_target_nxt  = r_target;
    w_meas_nxt    = r_meas;
    w_code_nxt    = r_code;
    w_bit_nxt     = r_bit;
    w_hits_nxt    = r_hits;
    w_lock_nxt    = r_lock;
    w_force_upd   = 1'b0;
    win_start     = 1'b0;
    busy          = (r_state != ST_IDLE);

    if ((r_state != ST_IDLE) && !en) begin
      // Loop disabled: abandon any window (a late meas_valid is simply never
      // looked at from IDLE), drop lock, hold the code.
      w_state_nxt = ST_IDLE;
      w_phase_nxt = PH_START;
      w_timer_nxt = '0;
      w_hits_nxt  = '0;
      w_lock_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_en_rise) begin
            w_win_len_nxt          = w_win_len_calc;
            w_target_nxt           = w_target_calc;
            w_code_nxt             = '0;
            w_code_nxt[CODE_W-1]   = 1'b1;
            w_bit_nxt              = BIT_W'(CODE_W - 1);
            w_force_upd            = 1'b1;
            w_hits_nxt             = '0;
            w_lock_nxt             = 1'b0;
            w_phase_nxt            = PH_START;
            w_timer_nxt            = '0;
            w_state_nxt            = ST_SAR_MEAS;
          end
        end

        ST_SAR_MEAS, ST_TRK_MEAS: begin
          case (r_phase)
            PH_START: begin
              win_start   = 1'b1;
              w_phase_nxt = PH_WIN;
              w_timer_nxt = '0;
            end
            PH_WIN: begin
              // The counter is still integrating; any meas_valid now is stale.
              if (r_timer == (TMR_W'(r_win_len) - TMR_W'(1))) begin
                w_phase_nxt = PH_WAIT;
                w_timer_nxt = '0;
              end else begin
                w_timer_nxt = r_timer + TMR_W'(1);
              end
            end
            PH_WAIT: begin
              if (meas_valid) begin
                w_meas_nxt  = meas_cnt;
                w_state_nxt = (r_state == ST_SAR_MEAS) ? ST_SAR_EVAL : ST_TRK_EVAL;
              end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                // A silent counter means CLK_out is dead: treat as zero edges.
                w_meas_nxt  = '0;
                w_state_nxt = (r_state == ST_SAR_MEAS) ? ST_SAR_EVAL : ST_TRK_EVAL;
              end else begin
                w_timer_nxt = r_timer + TMR_W'(1);
              end
            end
            default: begin
              w_phase_nxt = PH_START;
            end
          endcase
        end

        ST_SAR_EVAL: begin
          // Too few edges means CLK_out is too slow: drop this delay bit.
          if (r_meas < r_target) begin
            w_code_nxt[r_bit] = 1'b0;
          end
          if (r_bit != '0) begin
            w_code_nxt[r_bit - BIT_W'(1)] = 1'b1;
            w_bit_nxt                     = r_bit - BIT_W'(1);
            w_state_nxt                   = ST_SAR_MEAS;
          end else begin
            w_state_nxt = ST_TRK_MEAS;
          end
          w_phase_nxt = PH_START;
          w_timer_nxt = '0;
        end

        ST_TRK_EVAL: begin
          if (w_err > TOL_S) begin
            // CLK_out too fast: add one step of delay.
            if (r_code != '1) begin
              w_code_nxt = r_code + CODE_W'(1);
            end
            w_hits_nxt = '0;
            w_lock_nxt = 1'b0;
          end else if (w_err < -TOL_S) begin
            // CLK_out too slow: remove one step of delay.
            if (r_code != '0) begin
              w_code_nxt = r_code - CODE_W'(1);
            end
            w_hits_nxt = '0;
            w_lock_nxt = 1'b0;
          end else begin
            if (r_hits != HIT_W'(LOCK_HITS)) begin
              w_hits_nxt = r_hits + HIT_W'(1);
            end
            if (w_hits_nxt == HIT_W'(LOCK_HITS)) begin
              w_lock_nxt = 1'b1;
            end
          end
          w_phase_nxt = PH_START;
          w_timer_nxt = '0;
          w_state_nxt = ST_TRK_MEAS;
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_phase_nxt = PH_START;
          w_timer_nxt = '0;
        end
      endcase
    end

    // The update strobe follows the code register, plus the forced load on start.
    w_code_upd_nxt = w_force_upd | (w_code_nxt != r_code);
  end

  // State register with synchronous reset; rst overrides every other input.
  always_ff @(posedge CLK_exit) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_state    <= ST_IDLE;
      r_phase    <= PH_START;
      r_timer    <= '0;
      r_en_d     <= 1'b0;
      r_win_len  <= '0;
      r_target   <= '0;
      r_meas     <= '0;
      r_code     <= '0;
      r_bit      <= '0;
      r_hits     <= '0;
      r_lock     <= 1'b0;
      r_code_upd <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_timer    <= w_timer_nxt;
      r_en_d     <= en;
      r_win_len  <= w_win_len_nxt;
      r_target   <= w_target_nxt;
      r_meas     <= w_meas_nxt;
      r_code     <= w_code_nxt;
      r_bit      <= w_bit_nxt;
      r_hits     <= w_hits_nxt;
      r_lock     <= w_lock_nxt;
      r_code_upd <= w_code_upd_nxt;
    end
  end

endmodule

// File: tb/tb_fmdll_lock_ctrl.sv
// tb_fmdll_lock_ctrl
//   Directed bench for the FMDLL lock controller. A behavioural clock-count model
//   answers every win_start with a meas_valid pulse one cycle after the window;
//   its count is a function of dcdl_code selected per scenario.
module tb_fmdll_lock_ctrl;

  localparam int CODE_W = 10;
  localparam int CNT_W  = 9;

  typedef enum int {MD_FUNC, MD_ZERO, MD_SILENT, MD_CONST} mode_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [1:0]        M;
  logic [2:0]        N;
  logic              win_start;
  logic              meas_valid;
  logic [CNT_W-1:0]  meas_cnt;
  logic [CODE_W-1:0] dcdl_code;
  logic              code_upd;
  logic              lock;
  logic              busy;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;

  mode_t mode        = MD_FUNC;
  bit    offset_once = 1'b0;
  bit    decoy_on    = 1'b0;
  int    decoy_cnt   = 0;
  int    const_cnt   = 0;
  int    win_len_m   = 8;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  fmdll_lock_ctrl dut (
    .CLK_exit   (clk),
    .rst        (rst),
    .en         (en),
    .M          (M),
    .N          (N),
    .win_start  (win_start),
    .meas_valid (meas_valid),
    .meas_cnt   (meas_cnt),
    .dcdl_code  (dcdl_code),
    .code_upd   (code_upd),
    .lock       (lock),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance until the k-th win_start (the current cycle counts), bounded.
  task automatic wait_win(input int k, input string tag);
    int seen = 0;
    int n    = 0;
    while (seen < k) begin
      if (win_start === 1'b1) seen++;
      if (seen < k) begin
        @(negedge clk);
        n++;
        if (n > 300 * k) begin
          check({tag, "_timeout"}, seen, k);
          return;
        end
      end
    end
  endtask

  // Integer (floor) division: under this model the search settles at 127.
  function automatic int model_cnt(input int code);
    case (mode)
      MD_FUNC:  return 2048 / (code + 1) + (offset_once ? 3 : 0);
      MD_CONST: return const_cnt;
      default:  return 0;
    endcase
  endfunction

  // Clock-count model: window of win_len_m cycles, result one cycle later.
  initial begin
    meas_valid = 1'b0;
    meas_cnt   = '0;
    forever begin
      @(negedge clk);
      if (win_start === 1'b1 && !rst) begin
        repeat (win_len_m) @(negedge clk);
        if (decoy_on) begin
          meas_valid = 1'b1;
          meas_cnt   = CNT_W'(decoy_cnt);
        end
        @(negedge clk);
        meas_valid = (mode != MD_SILENT);
        meas_cnt   = CNT_W'(model_cnt(int'(dcdl_code)));
        if (mode == MD_FUNC) offset_once = 1'b0;
        @(negedge clk);
        meas_valid = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int n_upd;
    int n_busy;
    int n_lock;
    int n_nz;
    bit saw_valid;
    bit found;
    logic prev_lock;

    rst = 1'b1; en = 1'b1; M = 2'd1; N = 3'd0;

    // 1. Reset held 3 cycles with en high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_win_start", win_start, 0);
    end
    check("rst_code", dcdl_code, 0);
    check("rst_upd", code_upd, 0);
    check("rst_lock", lock, 0);
    check("rst_busy", busy, 0);
    en = 1'b0; rst = 1'b0;
    step(2);
    check("idle_busy", busy, 0);

    // 2. M=1, N=0: target 16, SAR settles at 127, lock after 4 windows.
    en = 1'b1;
    step(1);
    check("start_code", dcdl_code, 512);
    check("start_upd", code_upd, 1);
    check("start_win", win_start, 1);
    check("start_busy", busy, 1);
    step(1); wait_win(10, "sar");
    check("sar_code", dcdl_code, 127);
    check("sar_last_no_upd", code_upd, 0);
    check("sar_lock", lock, 0);
    step(1); wait_win(3, "trk3");
    check("lock_early", lock, 0);
    step(1); wait_win(1, "trk4");
    check("lock_set", lock, 1);
    check("lock_code", dcdl_code, 127);

    // 6. One window reading +3: lock drops, code +1, then relock.
    offset_once = 1'b1;
    prev_lock = lock;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step(1);
      if (code_upd === 1'b1) found = 1'b1;
      else prev_lock = lock;
    end
    check("err_upd_seen", found, 1);
    check("err_code", dcdl_code, 128);
    check("err_lock", lock, 0);
    check("err_prev_lock", prev_lock, 1);
    step(1); wait_win(3, "relock3");
    check("relock_early", lock, 0);
    step(1); wait_win(1, "relock4");
    check("relock", lock, 1);
    check("relock_code", dcdl_code, 128);

    // en drop while locked: idle, code held.
    en = 1'b0;
    step(1);
    check("drop_busy", busy, 0);
    check("drop_lock", lock, 0);
    check("drop_hold", dcdl_code, 128);
    step(20);

    // 5. en dropped mid-SAR at bit 5, late meas_valid ignored, then restart.
    en = 1'b1;
    step(1);
    check("reen1_code", dcdl_code, 512);
    step(1); wait_win(4, "to_bit5");
    check("sar_bit5", dcdl_code, 96);
    step(3);
    en = 1'b0;
    n_upd = 0; n_busy = 0; saw_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (code_upd === 1'b1) n_upd++;
      if (busy === 1'b1) n_busy++;
      if (meas_valid) saw_valid = 1'b1;
    end
    check("mid_valid_seen", saw_valid, 1);
    check("mid_no_upd", n_upd, 0);
    check("mid_no_busy", n_busy, 0);
    check("mid_hold", dcdl_code, 96);
    en = 1'b1;
    step(1);
    check("reen2_code", dcdl_code, 512);
    check("reen2_upd", code_upd, 1);
    en = 1'b0;
    step(20);

    // 3. Count always 0: SAR to 0, stays 0 in track without updates.
    mode = MD_ZERO;
    en = 1'b1;
    step(2); wait_win(10, "zero_sar");
    check("zero_code", dcdl_code, 0);
    check("zero_last_upd", code_upd, 1);
    n_upd = 0; n_lock = 0; n_nz = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (code_upd === 1'b1) n_upd++;
      if (lock === 1'b1) n_lock++;
      if (dcdl_code !== '0) n_nz++;
    end
    check("zero_trk_upd", n_upd, 0);
    check("zero_trk_lock", n_lock, 0);
    check("zero_trk_code", n_nz, 0);
    en = 1'b0;
    step(20);

    // 4. No meas_valid at all: every window times out after 8+255 cycles.
    mode = MD_SILENT;
    en = 1'b1;
    step(1);
    t0 = cyc;
    step(1); wait_win(1, "silent_w2");
    check("timeout_period", cyc - t0, 265);
    step(1); wait_win(9, "silent_sar");
    check("silent_code", dcdl_code, 0);
    en = 1'b0;
    step(20);

    // M=3, N=1: window 16, target 64; early decoy and later M/N changes ignored.
    mode = MD_CONST; const_cnt = 63; decoy_on = 1'b1; decoy_cnt = 200;
    M = 2'd3; N = 3'd1; win_len_m = 16;
    en = 1'b1;
    step(1);
    check("mn_start", dcdl_code, 512);
    t0 = cyc;
    M = 2'd0; N = 3'd0;
    step(1); wait_win(1, "mn_w2");
    check("mn_period", cyc - t0, 19);
    check("mn_bit9", dcdl_code, 256);
    const_cnt = 20;
    step(1); wait_win(1, "mn_w3");
    check("mn_bit8", dcdl_code, 128);

    // Reset while running wins over en.
    rst = 1'b1;
    step(1);
    check("rst_run_code", dcdl_code, 0);
    check("rst_run_busy", busy, 0);
    check("rst_run_upd", code_upd, 0);
    rst = 1'b0; en = 1'b0; decoy_on = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
